dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter NUM_LINES, default 32, number of direct-mapped cache lines.
REQ-002 Parameter LINE_BITS, default 256, line width in bits (32 bytes, 8 words).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 p_addr_i  input  32  CPU byte address (ALU result of memory stage).
REQ-006 p_data_i  input  32  CPU store data (RT register value).
REQ-007 p_MemRead_i  input  1  CPU load request.
REQ-008 p_MemWrite_i  input  1  CPU store request.
REQ-009 p_data_o  output  32  load data, word selected by p_addr_i[4:2].
REQ-010 p_stall_o  output  1  high = CPU must freeze PC and hold request stable.
REQ-011 mem_addr_o  output  32  line-aligned data-memory address, bits [4:0] always zero.
REQ-012 mem_data_o  output  256  writeback line data.
REQ-013 mem_enable_o  output  1  memory request valid.
REQ-014 mem_write_o  output  1  1 = write line, 0 = read line.
REQ-015 mem_data_i  input  256  refill line data, valid when mem_ack_i is high.
REQ-016 mem_ack_i  input  1  single-cycle completion pulse from data memory.

Function
REQ-017 Address split SHALL be offset [4:0], index [9:5], tag [31:10] (22 bits); each line holds valid, dirty, tag and 256 data bits.
REQ-018 Hit SHALL be defined as valid[index] AND stored tag == p_addr_i[31:10]; request = p_MemRead_i OR p_MemWrite_i.
REQ-019 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, REFILL.
REQ-020 IDLE, hit: p_stall_o = 0, p_data_o combinational from the selected word in the same cycle; a store writes p_data_i into the word and sets dirty at the clock edge.
REQ-021 IDLE, miss: p_stall_o = 1 combinationally; next state WRITEBACK if valid AND dirty, else ALLOCATE.
REQ-022 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {stored tag, index, 5'b0}, mem_data_o = stored line; on mem_ack_i go to ALLOCATE.
REQ-023 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {p_addr_i[31:5], 5'b0}; on mem_ack_i write mem_data_i, tag, valid = 1, dirty = 0; go to REFILL.
REQ-024 REFILL: one cycle with p_stall_o = 1 and mem_enable_o = 0; return to IDLE, where the held request hits.
REQ-025 p_stall_o SHALL be 1 in every non-IDLE state.
REQ-026 mem_enable_o SHALL stay high continuously until ack and deassert in the cycle after ack; mem_ack_i SHALL be ignored when mem_enable_o is 0.
REQ-027 Simultaneous p_MemRead_i and p_MemWrite_i SHALL be treated as a store; p_data_o then shows the pre-store word.
REQ-028 With no request, p_stall_o = 0 and no state changes occur.
REQ-029 mem_data_o SHALL be 0 outside WRITEBACK; p_data_o SHALL be 0 when there is no read request.

Reset
REQ-030 rst_i high SHALL immediately force state IDLE, all valid and dirty bits 0, and all outputs 0; the data array is not reset.
REQ-031 Reset during WRITEBACK or ALLOCATE SHALL abort the transfer (mem_enable_o drops asynchronously) and discard dirty data.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, OFFSET_W = 5, INDEX_W = 5, TAG_W = 22, and the line-width constant.
REQ-033 Tag and data storage SHALL be one sub-module, dcache_sram (tag/valid/dirty/data arrays, one write port, combinational read).

Verification
REQ-034 After reset, load from 0x0000_0004 -> p_stall_o = 1, ALLOCATE with mem_addr_o = 0x0; ack after 10 cycles with word1 = 0xDEADBEEF -> one REFILL cycle, then p_data_o = 0xDEADBEEF with p_stall_o = 0.
REQ-035 Store 0x12345678 to 0x0000_0008 (hit) -> no stall; a following load from 0x8 returns 0x12345678 with zero stall cycles.
REQ-036 Load from 0x0000_0408 (same index 0, dirty line) -> WRITEBACK with mem_addr_o = 0x0, mem_write_o = 1, word2 of mem_data_o = 0x12345678; then ALLOCATE with mem_addr_o = 0x400.
REQ-037 Assert rst_i mid-ALLOCATE -> mem_enable_o = 0 and p_stall_o = 0 immediately; a reload of 0x4 misses again.
REQ-038 Pulse mem_ack_i in IDLE with no request -> no state or array change; read+write together to a hit address -> store performed, dirty set.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants and FSM state type for the direct-mapped data cache.
package dcache_pkg;

  localparam int OFFSET_W = 5;
  localparam int INDEX_W  = 5;
  localparam int TAG_W    = 22;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one write port, combinational read.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = LINE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   index,
  input  logic                 we,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 wr_dirty,
  input  logic [LINE_BITS-1:0] wr_data,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid_bits;
  logic [NUM_LINES-1:0] dirty_bits;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];

  // Status bits are cleared by reset; every write leaves the line valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (we) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= wr_dirty;
    end
  end

  // Tag and data arrays carry no reset; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= wr_tag;
      data_mem[index] <= wr_data;
    end
  end

  assign rd_valid = valid_bits[index];
  assign rd_dirty = dirty_bits[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller with a
// four-state miss FSM (writeback of dirty victim, line allocate, refill bubble).
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = LINE_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p_addr_i,
  input  logic [31:0]          p_data_i,
  input  logic                 p_MemRead_i,
  input  logic                 p_MemWrite_i,
  output logic [31:0]          p_data_o,
  output logic                 p_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int WORDS = LINE_BITS / WORD_W;

  state_t state, state_next;

  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;
  logic [2:0]           word_sel;
  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic [LINE_BITS-1:0] store_line;
  logic [LINE_BITS-1:0] wr_data;
  logic [WORD_W-1:0]    cur_word;
  logic                 we, wr_dirty;
  logic                 request, hit;
  logic                 unused_addr_bits;

  assign index            = p_addr_i[OFFSET_W +: INDEX_W];
  assign tag              = p_addr_i[31 -: TAG_W];
  assign word_sel         = p_addr_i[4:2];
  assign unused_addr_bits = |p_addr_i[1:0];
  assign request          = p_MemRead_i | p_MemWrite_i;
  assign hit              = rd_valid && (rd_tag == tag);
  assign cur_word         = rd_data[{word_sel, 5'b0} +: WORD_W];

  // Stored line with the addressed word replaced by the store data.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_merge
    assign store_line[gi*WORD_W +: WORD_W] =
      (word_sel == 3'(gi)) ? p_data_i : rd_data[gi*WORD_W +: WORD_W];
  end

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk      (clk_i),
    .rst      (rst_i),
    .index    (index),
    .we       (we),
    .wr_tag   (tag),
    .wr_dirty (wr_dirty),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  // State register; reset aborts any memory transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, array write control and outputs; everything is forced low during reset.
  always_comb begin
    state_next   = state;
    p_stall_o    = 1'b0;
    p_data_o     = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    we           = 1'b0;
    wr_dirty     = 1'b0;
    wr_data      = store_line;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (request) begin
            if (hit) begin
              // A combined read+write is a store; the read port still shows the old word.
              if (p_MemRead_i) p_data_o = cur_word;
              if (p_MemWrite_i) begin
                we       = 1'b1;
                wr_dirty = 1'b1;
              end
            end else begin
              p_stall_o  = 1'b1;
              state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          p_stall_o    = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {rd_tag, index, 5'b0};
          mem_data_o   = rd_data;
          if (mem_ack_i) state_next = ALLOCATE;
        end
        ALLOCATE: begin
          p_stall_o    = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {p_addr_i[31:5], 5'b0};
          if (mem_ack_i) begin
            we         = 1'b1;
            wr_dirty   = 1'b0;
            wr_data    = mem_data_i;
            state_next = REFILL;
          end
        end
        REFILL: begin
          p_stall_o  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios followed by
// random loads/stores against an array-based cache and memory model.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p_addr_i;
  logic [31:0]  p_data_i;
  logic         p_MemRead_i;
  logic         p_MemWrite_i;
  logic [31:0]  p_data_o;
  logic         p_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;

  // Reference state: cache lines and a backing memory for tags 0..3.
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  logic [255:0] mem     [128];

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p_addr_i     (p_addr_i),
    .p_data_i     (p_data_i),
    .p_MemRead_i  (p_MemRead_i),
    .p_MemWrite_i (p_MemWrite_i),
    .p_data_o     (p_data_o),
    .p_stall_o    (p_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Acts as data memory for one transfer: checks the request each cycle, acks after lat cycles.
  task automatic mem_phase(input bit exp_write, input logic [31:0] exp_addr,
                           input logic [255:0] line, input int lat);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk_i); #1;
      check(exp_write ? "wb_ctrl" : "alloc_ctrl", {mem_enable_o, mem_write_o, p_stall_o},
            {1'b1, exp_write, 1'b1});
      check(exp_write ? "wb_addr" : "alloc_addr", mem_addr_o, exp_addr);
      check(exp_write ? "wb_data" : "alloc_mem_data_o", mem_data_o, exp_write ? line : '0);
      if (c == lat - 1) begin
        mem_ack_i  = 1'b1;
        mem_data_i = exp_write ? rand_line() : line;
      end
    end
    @(posedge clk_i); #1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  // One CPU access held until it completes as a hit.
  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata, input int lat_req);
    logic [4:0]  ix;
    logic [21:0] tg;
    logic [2:0]  w;
    logic [31:0] exp_word;
    bit          hit;
    int          lat;
    ix  = addr[9:5];
    tg  = addr[31:10];
    w   = addr[4:2];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    lat = (lat_req > 0) ? lat_req : int'($urandom_range(1, 4));
    @(negedge clk_i);
    p_addr_i = addr; p_MemRead_i = rd; p_MemWrite_i = wr; p_data_i = wdata;
    #1;
    if (!hit) begin
      check("miss_stall", {p_stall_o, mem_enable_o}, 2'b10);
      if (m_valid[ix] && m_dirty[ix]) begin
        mem_phase(1'b1, {m_tag[ix], ix, 5'b0}, m_data[ix], lat);
        mem[{m_tag[ix][1:0], ix}] = m_data[ix];
      end
      mem_phase(1'b0, {addr[31:5], 5'b0}, mem[addr[11:5]], lat);
      m_valid[ix] = 1'b1; m_dirty[ix] = 1'b0; m_tag[ix] = tg; m_data[ix] = mem[addr[11:5]];
      @(negedge clk_i); #1;
      check("refill", {p_stall_o, mem_enable_o}, 2'b10);
      @(negedge clk_i); #1;
    end
    exp_word = rd ? m_data[ix][w*32 +: 32] : 32'h0;
    check("hit_stall", p_stall_o, 1'b0);
    check("load_data", p_data_o, exp_word);
    if (wr) begin
      m_data[ix][w*32 +: 32] = wdata;
      m_dirty[ix] = 1'b1;
    end
    txn++;
    $display("txn %0d addr=%h rd=%0b wr=%0b wdata=%h hit=%0b p_data_o=%h",
             txn, addr, rd, wr, wdata, hit, p_data_o);
  endtask

  // One cycle with no request, optionally with a stray ack pulse.
  task automatic idle_cycle(input bit stray_ack);
    @(negedge clk_i);
    p_MemRead_i = 1'b0; p_MemWrite_i = 1'b0; p_data_i = $urandom;
    mem_ack_i = stray_ack; mem_data_i = stray_ack ? rand_line() : '0;
    #1;
    check("idle_outputs", {p_stall_o, mem_enable_o, p_data_o}, '0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_data_i = '0;
    txn++;
    $display("txn %0d idle stray_ack=%0b", txn, stray_ack);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    for (int i = 0; i < 128; i++) mem[i] = rand_line();
    for (int i = 0; i < 32; i++) begin
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
    clear_model();
    mem[0][63:32] = 32'hDEADBEEF;

    // Reset with a pending load: every output must be low.
    rst_i = 1'b1; p_addr_i = 32'h4; p_data_i = '0; p_MemRead_i = 1'b1; p_MemWrite_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    #3;
    check("reset_outputs", {p_stall_o, mem_enable_o, mem_write_o, mem_addr_o, p_data_o}, '0);
    check("reset_mem_data", mem_data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b0; p_MemRead_i = 1'b0;

    // Cold miss with a 10-cycle memory, then store hit, load hit, dirty eviction.
    access(32'h0000_0004, 1'b1, 1'b0, 32'h0, 10);
    check("deadbeef", p_data_o, 32'hDEADBEEF);
    access(32'h0000_0008, 1'b0, 1'b1, 32'h1234_5678, 0);
    access(32'h0000_0008, 1'b1, 1'b0, 32'h0, 0);
    check("store_then_load", p_data_o, 32'h1234_5678);
    access(32'h0000_0408, 1'b1, 1'b0, 32'h0, 3);

    // Reset in the middle of an allocate.
    @(negedge clk_i);
    p_addr_i = 32'h4; p_MemRead_i = 1'b1; p_MemWrite_i = 1'b0;
    #1;
    check("pre_reset_miss", p_stall_o, 1'b1);
    @(negedge clk_i); #1;
    check("alloc_active", {mem_enable_o, mem_addr_o}, {1'b1, 32'h0});
    rst_i = 1'b1;
    #1;
    check("reset_abort", {p_stall_o, mem_enable_o, mem_addr_o}, '0);
    @(negedge clk_i);
    rst_i = 1'b0; p_MemRead_i = 1'b0;
    clear_model();
    access(32'h0000_0004, 1'b1, 1'b0, 32'h0, 2);

    // Stray ack in idle is ignored; read+write together stores and dirties the line.
    idle_cycle(1'b1);
    access(32'h0000_0004, 1'b1, 1'b0, 32'h0, 0);
    access(32'h0000_0004, 1'b1, 1'b1, 32'hCAFE_F00D, 0);
    access(32'h0000_0400, 1'b1, 1'b0, 32'h0, 2);
    access(32'h0000_0004, 1'b1, 1'b0, 32'h0, 2);
    check("rw_store_kept", p_data_o, 32'hCAFE_F00D);

    // Random traffic over four tags and four indices to force conflicts.
    for (int n = 0; n < 200; n++) begin
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      op = $urandom_range(0, 4);
      case (op)
        0, 1: access(a, 1'b1, 1'b0, 32'h0, 0);
        2:    access(a, 1'b0, 1'b1, $urandom, 0);
        3:    access(a, 1'b1, 1'b1, $urandom, 0);
        default: idle_cycle($urandom_range(0, 1) == 1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
